// File: rtl/tile_pkg.sv
// Shared tile types: sequencer state encoding and default word geometry.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_WORDS = 4;

endpackage

// File: rtl/add_slice.sv
// One WIDTH-bit adder slice with carry in/out; the only adder in the tile.
module add_slice #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] sum_c;

  assign sum_c     = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
  assign {cout, s} = sum_c;

endmodule

// File: rtl/multiword_add_ctrl.sv
// Word-serial wide add/subtract: steps one add_slice over the operand words,
// least-significant first, chaining the carry through a register.
module multiword_add_ctrl
  import tile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   on_off,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_carry,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_carry,
  output logic                   busy
);

  localparam int unsigned TOTAL = WIDTH * WORDS;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e             state_q, state_d;
  logic [TOTAL-1:0]   op_a_q, op_a_d;
  logic [TOTAL-1:0]   op_b_q, op_b_d;
  logic [TOTAL-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               out_carry_q, out_carry_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   a_word, b_word, s_word;
  logic               cout;

  // Select the operand word currently addressed by idx.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        a_word = op_a_q[w*WIDTH +: WIDTH];
        b_word = op_b_q[w*WIDTH +: WIDTH];
      end
    end
  end

  add_slice #(.WIDTH(WIDTH)) u_slice (
    .a   (a_word),
    .b   (b_word),
    .cin (carry_q),
    .s   (s_word),
    .cout(cout)
  );

  assign in_ready  = (state_q == IDLE) && on_off && reset_n;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_carry = out_carry_q;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_carry_d = out_carry_q;
    out_valid_d = out_valid_q;

    if (!on_off) begin
      // Tile disabled: discard any in-flight op and clear the result.
      state_d     = IDLE;
      out_valid_d = 1'b0;
      carry_d     = 1'b0;
      idx_d       = '0;
      sum_d       = '0;
      out_carry_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtract is A + ~B + 1, so the carry-in is forced high.
            op_a_d  = in_a;
            op_b_d  = in_sub ? ~in_b : in_b;
            carry_d = in_sub ? 1'b1 : in_carry;
            idx_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) sum_d[w*WIDTH +: WIDTH] = s_word;
          end
          carry_d = cout;
          if (idx_q == IDX_W'(WORDS - 1)) begin
            out_carry_d = cout;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_carry_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_carry_q <= out_carry_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
